seq_stim_gen: RTL and testbench
===============================

# seq_stim_gen

Programmable stimulus source placed directly upstream of the sequential processing modules in the HDL test flow. On a `start` pulse it captures a mode, seed and beat count, then emits that many data beats over a valid/ready stream. It marks the final beat and pulses `done` when the burst completes. It supports incrementing-counter, Galois-LFSR, constant and walking-one patterns.

## Interface
Parameters:
- `DATA_W`, default 8, beat width; LFSR mode is defined for 8 and 16 only.
- `LEN_W`, default 8, width of the beat-count input.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `mode`  in  2  0 = counter, 1 = LFSR, 2 = constant, 3 = walking-one; captured at start.
- `seed`  in  DATA_W  initial value; captured at start.
- `len`  in  LEN_W  number of beats; captured at start.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  DATA_W  beat payload.
- `out_last`  out  1  high with the final beat of a burst.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final beat transfers.

## Operation
- FSM states:
  - IDLE: on `start` with `len != 0`, capture inputs, load beat counter = `len`, go to RUN. `start` with `len == 0` is ignored and produces no `done`.
  - RUN: `out_valid = 1`. A transfer occurs on `out_valid && out_ready`. On each transfer the counter decrements and the data advances. The transfer with counter == 1 goes to DONE.
  - DONE: `done = 1` for exactly one cycle, then return to IDLE. `start` is ignored in this state.
- Data rules, with index k starting at 0:
  - counter: seed+k, modulo 2^DATA_W.
  - LFSR: first beat is seed, replaced by 1 if seed == 0. Next value = (d >> 1) ^ (d[0] ? TAPS : 0), with TAPS = 0xB8 for DATA_W = 8 and 0xB400 for DATA_W = 16.
  - constant: seed on every beat.
  - walking-one: 1 << (k mod DATA_W); seed is ignored.
- `out_last` = RUN && counter == 1.
- `start` during RUN or DONE has no effect; mode, seed and len changes after capture have no effect.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0, `done` = 0, state = IDLE. Asserting reset mid-burst aborts immediately with no `done`.

## Timing
- `start` sampled in cycle N gives `out_valid` = 1 and first beat on `out_data` in cycle N+1. `busy` rises in the same cycle.
- Handshake: once `out_valid` is asserted, `out_data` and `out_last` stay stable until the transfer. `out_valid` never drops mid-burst without a transfer, except on reset.
- With `out_ready` held high, one beat transfers per cycle. A burst of L beats occupies cycles N+1..N+L.
- Final transfer in cycle M: cycle M+1 has `done` = 1, `busy` = 0, `out_valid` = 0. Cycle M+2 is IDLE and can accept `start`.
- `out_valid` does not depend combinationally on `out_ready`.

## Configuration
- Macro: `SEQ_STIM_PAUSE_EN`.
- Defined:
  - Adds input port `pause` (1 bit).
  - While `pause` = 1 in RUN, no new beat is presented.
  - A beat already presented (`out_valid` = 1) stays valid and transfers normally.
  - After that transfer, `out_valid` stays 0 while `pause` = 1.
  - After `pause` drops, `out_valid` reasserts the next cycle.
- Undefined: no `pause` port; behaviour is as if `pause` = 0.

## Test plan
- Counter, seed = 0xFE, len = 4, ready = 1 -> data FE, FF, 00, 01 in consecutive cycles; `out_last` only on 01; `done` one cycle later.
- LFSR, DATA_W = 8, seed = 0x01, len = 3 -> data 01, B8, 5C; a seed of 0x00 yields the same sequence.
- Walking-one, len = 10, ready low for 3 cycles during beat 2 -> data 01, 02, 04, …, 80, 01, 02; beat 2 (04) held stable with `out_valid` high through the stall.
- `start` with len = 0, then `start` during RUN -> the first is ignored (no `busy`, no `done`); the second leaves the in-progress burst unchanged.
- `rst` low in the middle of a 5-beat burst -> all outputs 0 asynchronously, no `done`; a new `start` after reset release runs a full burst.
- With `SEQ_STIM_PAUSE_EN`: pause asserted after beat 1 transfers, for 4 cycles -> no `out_valid` for 4 cycles; beat 2 appears the cycle after `pause` drops.

Source files
------------

// File: rtl/seq_stim_gen.sv
// Programmable burst stimulus source: counter / LFSR / constant / walking-one beats on a valid/ready stream.
// Optional `pause` input enabled by defining SEQ_STIM_PAUSE_EN.
module seq_stim_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  len,
`ifdef SEQ_STIM_PAUSE_EN
    input  logic              pause,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] M_CNT   = 2'd0;
    localparam logic [1:0] M_LFSR  = 2'd1;
    localparam logic [1:0] M_CONST = 2'd2;
    localparam logic [1:0] M_WALK  = 2'd3;

    localparam logic [DATA_W-1:0] TAPS = (DATA_W == 16) ? DATA_W'(16'hB400) : DATA_W'(8'hB8);
    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

    state_t             state;
    logic [1:0]         mode_q;
    logic [LEN_W-1:0]   cnt;
    logic [DATA_W-1:0]  first_data;
    logic [DATA_W-1:0]  next_data;
    logic               pause_i;
    logic               xfer;

`ifdef SEQ_STIM_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign xfer = out_valid && out_ready;

    always_comb begin
        first_data = seed;
        case (mode)
            M_LFSR:  first_data = (seed == '0) ? ONE : seed;
            M_WALK:  first_data = ONE;
            default: first_data = seed;
        endcase
    end

    // Next beat is derived from the beat currently on the bus.
    always_comb begin
        next_data = out_data;
        case (mode_q)
            M_CNT:   next_data = out_data + ONE;
            M_LFSR:  next_data = (out_data >> 1) ^ (out_data[0] ? TAPS : '0);
            M_CONST: next_data = out_data;
            M_WALK:  next_data = {out_data[DATA_W-2:0], out_data[DATA_W-1]};
            default: next_data = out_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= M_CNT;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && len != '0) begin
                        state     <= RUN;
                        mode_q    <= mode;
                        cnt       <= len;
                        out_data  <= first_data;
                        out_valid <= ~pause_i;
                        out_last  <= (len == LEN_W'(1));
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        cnt      <= cnt - LEN_W'(1);
                        out_data <= next_data;
                        if (cnt == LEN_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_valid <= ~pause_i;
                            out_last  <= (cnt == LEN_W'(2));
                        end
                    end else if (!out_valid) begin
                        // A presented beat is never withdrawn; only an idle slot waits on pause.
                        out_valid <= ~pause_i;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: directed bursts push expected beats, a monitor pops on each transfer.
module tb_seq_stim_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] seed = 8'd0;
    logic [7:0] len = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef SEQ_STIM_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic [8:0] exp_q[$];

    seq_stim_gen #(.DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .len(len),
`ifdef SEQ_STIM_PAUSE_EN
        .pause(pause),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && done) done_seen++;
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected beat %0h last %0b", out_data, out_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got data %0h last %0b expected data %0h last %0b",
                             out_data, out_last, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Pulse start for one cycle; returns 1ns into the first beat cycle.
    task automatic kick(input logic [1:0] m, input logic [7:0] s, input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1; mode = m; seed = s; len = l;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'd2; seed = 8'hEE; len = 8'd7;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin cyc = i; break; end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end else begin
            check("done_busy", busy, 0);
            check("done_valid", out_valid, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    int cyc;

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;

        // Counter wrap: FE FF 00 01, back-to-back
        push(8'hFE, 0); push(8'hFF, 0); push(8'h00, 0); push(8'h01, 1);
        kick(2'd0, 8'hFE, 8'd4);
        check("cnt_busy_rise", busy, 1);
        check("cnt_valid_rise", out_valid, 1);
        check("cnt_first_data", out_data, 8'hFE);
        done_exp++;
        wait_done(cyc);
        check("cnt_done_latency", cyc, 4);

        // LFSR, seed 01 and seed 00 give the same sequence
        push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 1);
        kick(2'd1, 8'h01, 8'd3);
        done_exp++;
        wait_done(cyc);
        push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 1);
        kick(2'd1, 8'h00, 8'd3);
        done_exp++;
        wait_done(cyc);

        // Walking-one with 3-cycle stall on beat 2
        push(8'h01, 0); push(8'h02, 0); push(8'h04, 0); push(8'h08, 0); push(8'h10, 0);
        push(8'h20, 0); push(8'h40, 0); push(8'h80, 0); push(8'h01, 0); push(8'h02, 1);
        kick(2'd3, 8'h55, 8'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 8'h04);
            check("stall_last", out_last, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        done_exp++;
        wait_done(cyc);

        // start with len 0 is ignored
        kick(2'd0, 8'h33, 8'd0);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        repeat (3) @(posedge clk);

        // start during RUN leaves burst unchanged
        push(8'h10, 0); push(8'h11, 0); push(8'h12, 1);
        kick(2'd0, 8'h10, 8'd3);
        start = 1'b1; mode = 2'd3; seed = 8'h99; len = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        done_exp++;
        wait_done(cyc);
        check("len0_no_extra_done", done_seen, done_exp);

        // Reset mid-burst: beats 20,21 transfer, then abort
        push(8'h20, 0); push(8'h21, 0);
        kick(2'd0, 8'h20, 8'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_seen, done_exp);
        push(8'h5A, 0); push(8'h5A, 1);
        kick(2'd2, 8'h5A, 8'd2);
        done_exp++;
        wait_done(cyc);
        check("post_rst_latency", cyc, 2);

`ifdef SEQ_STIM_PAUSE_EN
        // Pause after first transfer: 4 idle cycles, then beat resumes
        push(8'h40, 0); push(8'h41, 0); push(8'h42, 1);
        kick(2'd0, 8'h40, 8'd3);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) pause = 1'b0;
            @(negedge clk);
            check("pause_valid_low", out_valid, 0);
        end
        @(posedge clk); #1;
        check("pause_resume_valid", out_valid, 1);
        check("pause_resume_data", out_data, 8'h41);
        done_exp++;
        wait_done(cyc);
`endif

        repeat (2) @(negedge clk);
        check("done_count", done_seen, done_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
